// File: rtl/oscillo_acq_pkg.sv
// oscillo_acq_pkg: shared defaults, output word layout and word builder for the acquisition arbiter
package oscillo_acq_pkg;
   localparam int SAMPLE_W_DEF   = 12;
   localparam int FIFO_DEPTH_DEF = 16;
   localparam int WORD_W         = 16;
   localparam int CHAN_BIT       = 15;
   localparam int OVF_BIT        = 14;
   localparam int SAMPLE_LSB     = 0;
   localparam int SAMPLE_FIELD_W = 12;

   typedef struct packed {
      logic                      chan;
      logic                      ovf;
      logic [1:0]                zero;
      logic [SAMPLE_FIELD_W-1:0] sample;
   } acq_word_t;

   function automatic acq_word_t make_word(input logic chan, input logic ovf,
                                           input logic [SAMPLE_FIELD_W-1:0] sample);
      logic [WORD_W-1:0] w;
      w = '0;
      w[CHAN_BIT] = chan;
      w[OVF_BIT] = ovf;
      w[SAMPLE_LSB +: SAMPLE_FIELD_W] = sample;
      return acq_word_t'(w);
   endfunction
endpackage

// File: rtl/acq_sample_fifo.sv
// acq_sample_fifo: show-ahead synchronous FIFO with count-based flags; a full FIFO still takes a write when popped the same cycle
module acq_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_i,
   input  logic [W-1:0] wdata_i,
   input  logic         rd_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o,
   output logic         wr_ok_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          rd_ok, wr_en;

   assign empty_o = cnt_q == '0;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign rd_ok   = rd_i && !empty_o;
   assign wr_ok_o = !full_o || rd_ok;
   assign wr_en   = wr_i && wr_ok_o;
   assign rdata_o = empty_o ? '0 : mem_q[rp_q];

   always_comb begin
      wp_d  = wr_en ? wp_q + 1'b1 : wp_q;
      rp_d  = rd_ok ? rp_q + 1'b1 : rp_q;
      cnt_d = (wr_en && !rd_ok) ? cnt_q + 1'b1 : (!wr_en && rd_ok) ? cnt_q - 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wp_q] <= wdata_i;
   end
endmodule

// File: rtl/acq_sample_arbiter.sv
// acq_sample_arbiter: two-channel ADC sample capture into one-entry holding registers,
// round-robin arbitration on contention, and a shared show-ahead sample FIFO
module acq_sample_arbiter
   import oscillo_acq_pkg::*;
#(
   parameter int SAMPLE_W   = SAMPLE_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          i_chan_enable,
   input  logic                i_chan0_strobe,
   input  logic                i_chan1_strobe,
   input  logic [SAMPLE_W-1:0] i_chan0_data,
   input  logic [SAMPLE_W-1:0] i_chan1_data,
   input  logic                userif_SampleRead,
   output logic [15:0]         userif_SampleData,
   output logic                userif_SampleEmpty,
   output logic                o_fifo_full,
   output logic [7:0]          o_drop_count0,
   output logic [7:0]          o_drop_count1
);
   logic [1:0]          hold_v_q, hold_v_d, ovf_q, ovf_d, strobe, cap, drop, gnt;
   logic [SAMPLE_W-1:0] hold_q [2];
   logic [SAMPLE_W-1:0] hold_d [2];
   logic [SAMPLE_W-1:0] data [2];
   logic [7:0]          drop_q [2];
   logic [7:0]          drop_d [2];
   logic                last_q, last_d, wr_ok, wr;
   acq_word_t           wdata;

   assign strobe = {i_chan1_strobe, i_chan0_strobe};
   assign data[0] = i_chan0_data;
   assign data[1] = i_chan1_data;
   assign o_drop_count0 = drop_q[0];
   assign o_drop_count1 = drop_q[1];

   always_comb begin
      gnt[0] = wr_ok && hold_v_q[0] && (!hold_v_q[1] || last_q);
      gnt[1] = wr_ok && hold_v_q[1] && (!hold_v_q[0] || !last_q);
      wr     = |gnt;
      wdata  = gnt[1] ? make_word(1'b1, ovf_q[1], SAMPLE_FIELD_W'(hold_q[1]))
                      : make_word(1'b0, ovf_q[0], SAMPLE_FIELD_W'(hold_q[0]));
      // only a contended grant moves the round-robin pointer
      last_d = (&hold_v_q && wr) ? gnt[1] : last_q;
      for (int c = 0; c < 2; c++) begin
         cap[c]      = strobe[c] && i_chan_enable[c];
         drop[c]     = cap[c] && hold_v_q[c] && !gnt[c];
         hold_v_d[c] = cap[c] || (hold_v_q[c] && !gnt[c]);
         hold_d[c]   = (cap[c] && !drop[c]) ? data[c] : hold_q[c];
         ovf_d[c]    = drop[c] || (ovf_q[c] && !gnt[c]);
         drop_d[c]   = (drop[c] && drop_q[c] != 8'hFF) ? drop_q[c] + 8'd1 : drop_q[c];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_v_q  <= '0;
         ovf_q     <= '0;
         last_q    <= 1'b1;
         hold_q[0] <= '0;
         hold_q[1] <= '0;
         drop_q[0] <= '0;
         drop_q[1] <= '0;
      end else begin
         hold_v_q  <= hold_v_d;
         ovf_q     <= ovf_d;
         last_q    <= last_d;
         hold_q[0] <= hold_d[0];
         hold_q[1] <= hold_d[1];
         drop_q[0] <= drop_d[0];
         drop_q[1] <= drop_d[1];
      end
   end

   acq_sample_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr),
      .wdata_i (wdata),
      .rd_i    (userif_SampleRead),
      .rdata_o (userif_SampleData),
      .empty_o (userif_SampleEmpty),
      .full_o  (o_fifo_full),
      .wr_ok_o (wr_ok)
   );
endmodule
